uart_tx_serializer: RTL and testbench

Byte-to-serial UART transmitter, 8N1 by default. It sits directly downstream of the result Transmitter and consumes its `start` and `ascii_code` pair, driving the board TX pin.
It reports frame completion with a one-cycle `r_next` pulse, which the Transmitter uses to sequence the next character. Holding `start` high sends back-to-back frames, and the data is re-sampled for each frame.

---
 rtl/uart_pkg.sv | 19 +
 rtl/baud_tick_gen.sv | 28 ++
 rtl/uart_tx_serializer.sv | 130 +++++++++++++
 tb/tb_uart_tx_serializer.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART types, constants and baud helper
package uart_pkg;

    localparam int DATA_BITS = 8;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        GUARD
    } tx_state_t;

    function automatic int clks_per_bit(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

endpackage

// File: rtl/baud_tick_gen.sv
// rtl/baud_tick_gen.sv - bit-period counter with clear and end-of-bit tick
module baud_tick_gen #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    output logic tick
);

    localparam int W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [W-1:0] LAST = W'(CLKS_PER_BIT - 1);

    logic [W-1:0] count;

    assign tick = !clear && (count == LAST);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear || tick) begin
            count <= '0;
        end else begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/uart_tx_serializer.sv
// rtl/uart_tx_serializer.sv - 8N1/8N2 UART transmitter; UART_TX_PARITY_EN adds an even parity bit
module uart_tx_serializer
    import uart_pkg::*;
#(
    parameter int CLK_FREQ     = 100000000,
    parameter int BAUD         = 115200,
    parameter int CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD),
    parameter int STOP_BITS    = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] data,
    output logic       t,
    output logic       r_next,
    output logic       busy
);

    localparam logic [2:0] LAST_DATA = 3'(DATA_BITS - 1);
    localparam logic [2:0] LAST_STOP = 3'(STOP_BITS - 1);

    tx_state_t            state;
    logic [DATA_BITS-1:0] shreg;
    logic [2:0]           idx;
    logic                 tick;
    logic                 clear;
`ifdef UART_TX_PARITY_EN
    logic                 parity;
`endif

    // Every timed state leaves on a tick, so the counter is already 0 there;
    // only the untimed states need an explicit hold.
    assign clear = (state == IDLE) || (state == GUARD);

    baud_tick_gen #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (clear),
        .tick  (tick)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            t      <= 1'b1;
            r_next <= 1'b0;
            busy   <= 1'b0;
            shreg  <= '0;
            idx    <= '0;
`ifdef UART_TX_PARITY_EN
            parity <= 1'b0;
`endif
        end else begin
            r_next <= 1'b0;
            case (state)
                IDLE: begin
                    t <= 1'b1;
                    if (start) begin
                        shreg <= data;
                        idx   <= '0;
                        t     <= 1'b0;
                        busy  <= 1'b1;
                        state <= START;
`ifdef UART_TX_PARITY_EN
                        parity <= ^data;
`endif
                    end
                end
                START: begin
                    if (tick) begin
                        idx   <= '0;
                        t     <= shreg[0];
                        state <= DATA;
                    end
                end
                DATA: begin
                    if (tick) begin
                        shreg <= shreg >> 1;
                        idx   <= idx + 3'd1;
                        if (idx == LAST_DATA) begin
`ifdef UART_TX_PARITY_EN
                            t     <= parity;
                            state <= PARITY;
`else
                            t     <= 1'b1;
                            state <= STOP;
`endif
                        end else begin
                            t <= shreg[1];
                        end
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    if (tick) begin
                        idx   <= '0;
                        t     <= 1'b1;
                        state <= STOP;
                    end
                end
`endif
                STOP: begin
                    t <= 1'b1;
                    if (tick) begin
                        if (idx == LAST_STOP) begin
                            idx    <= '0;
                            r_next <= 1'b1;
                            state  <= GUARD;
                        end else begin
                            idx <= idx + 3'd1;
                        end
                    end
                end
                GUARD: begin
                    t     <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    t     <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// tb/tb_uart_tx_serializer.sv - directed vector bench for uart_tx_serializer
`timescale 1ns/1ps
module tb_uart_tx_serializer;

    localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    localparam int FRAME_CYC = NBITS * CPB;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [7:0] data = 8'h00;
    logic       t;
    logic       r_next;
    logic       busy;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    uart_tx_serializer #(
        .CLKS_PER_BIT(CPB),
        .STOP_BITS(1)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .data   (data),
        .t      (t),
        .r_next (r_next),
        .busy   (busy)
    );

    // frame holds the 8N1 line bits in transmit order, bit 0 = start bit
    typedef struct {
        logic [7:0] data;
        logic [9:0] frame;
        logic       par;
    } vec_t;

    vec_t vecs[8];

    task automatic chk1(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic chki(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [10:0] seq_of(input vec_t v);
`ifdef UART_TX_PARITY_EN
        return {1'b1, v.par, v.frame[8:0]};
`else
        return {1'b0, v.frame};
`endif
    endfunction

    // Entered at the first negedge after acceptance; leaves at the guard cycle.
    task automatic watch_frame(input string name, input logic [10:0] seq, input int pulse_k);
        int early = 0;
        for (int k = 1; k <= FRAME_CYC; k++) begin
            if (k == pulse_k) start = 1'b1;
            else if (pulse_k != 0 && k == pulse_k + 1) start = 1'b0;
            chk1($sformatf("%s t k=%0d", name, k), t, seq[(k-1)/CPB]);
            chk1($sformatf("%s busy k=%0d", name, k), busy, 1'b1);
            if (r_next) early++;
            @(negedge clk);
        end
        chki({name, " r_next_early"}, early, 0);
        chk1({name, " r_next_guard"}, r_next, 1'b1);
        chk1({name, " t_guard"}, t, 1'b1);
        chk1({name, " busy_guard"}, busy, 1'b1);
    endtask

    task automatic send_frame(input string name, input logic [7:0] d,
                              input logic [10:0] seq, input int pulse_k);
        int late = 0;
        start = 1'b1;
        data  = d;
        @(negedge clk);
        start = 1'b0;
        data  = ~d;
        watch_frame(name, seq, pulse_k);
        @(negedge clk);
        chk1({name, " idle_busy"}, busy, 1'b0);
        chk1({name, " idle_r_next"}, r_next, 1'b0);
        chk1({name, " idle_t"}, t, 1'b1);
        for (int i = 0; i < 2 * CPB; i++) begin
            @(negedge clk);
            if (r_next || busy || !t) late++;
        end
        chki({name, " tail_quiet"}, late, 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        int quiet;
        vecs[0] = '{8'h41, 10'b1_01000001_0, 1'b0};
        vecs[1] = '{8'h00, 10'b1_00000000_0, 1'b0};
        vecs[2] = '{8'hFF, 10'b1_11111111_0, 1'b0};
        vecs[3] = '{8'h55, 10'b1_01010101_0, 1'b0};
        vecs[4] = '{8'h07, 10'b1_00000111_0, 1'b1};
        vecs[5] = '{8'h80, 10'b1_10000000_0, 1'b1};
        vecs[6] = '{8'h0D, 10'b1_00001101_0, 1'b1};
        vecs[7] = '{8'h31, 10'b1_00110001_0, 1'b1};

        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk1("reset t", t, 1'b1);
        chk1("reset r_next", r_next, 1'b0);
        chk1("reset busy", busy, 1'b0);
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk1($sformatf("idle t c=%0d", i), t, 1'b1);
            chk1($sformatf("idle r_next c=%0d", i), r_next, 1'b0);
            chk1($sformatf("idle busy c=%0d", i), busy, 1'b0);
        end

        for (int i = 0; i < 8; i++) begin
            send_frame($sformatf("vec%0d", i), vecs[i].data, seq_of(vecs[i]), 0);
        end

        // back-to-back with start held; data swapped when r_next is seen
        start = 1'b1;
        data  = vecs[7].data;
        @(negedge clk);
        watch_frame("b2b0", seq_of(vecs[7]), 0);
        data = vecs[6].data;
        @(negedge clk);
        chk1("b2b gap t", t, 1'b1);
        chk1("b2b gap busy", busy, 1'b0);
        chk1("b2b gap r_next", r_next, 1'b0);
        @(negedge clk);
        watch_frame("b2b1", seq_of(vecs[6]), 0);
        start = 1'b0;
        @(negedge clk);
        chk1("b2b end busy", busy, 1'b0);
        quiet = 0;
        for (int i = 0; i < 2 * CPB; i++) begin
            @(negedge clk);
            if (r_next || busy || !t) quiet++;
        end
        chki("b2b no third frame", quiet, 0);

        // reset during data bit 3 (line bits 17..20 after acceptance)
        start = 1'b1;
        data  = 8'hA5;
        @(negedge clk);
        start = 1'b0;
        repeat (17) @(negedge clk);
        chk1("abort pre t", t, 1'b0);
        rst_n = 1'b0;
        @(negedge clk);
        chk1("abort t", t, 1'b1);
        chk1("abort busy", busy, 1'b0);
        chk1("abort r_next", r_next, 1'b0);
        rst_n = 1'b1;
        quiet = 0;
        for (int i = 0; i < FRAME_CYC + 10; i++) begin
            @(negedge clk);
            if (r_next || busy || !t) quiet++;
        end
        chki("abort quiet", quiet, 0);
        send_frame("post_abort", vecs[0].data, seq_of(vecs[0]), 0);

        send_frame("pulse_mid", vecs[3].data, seq_of(vecs[3]), 10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
